// File: rtl/vm80_intc.sv
// Eight-input priority interrupt controller answering the vm80a INTA cycle with RST n,
// plus a small CPU-visible register window for mask, pending and in-service state.
module vm80_intc #(
    parameter logic [7:0] BASE     = 8'hFD,
    parameter logic [2:0] SPUR_VEC = 3'd7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [7:0]  din,
    input  logic        sync,
    input  logic        dbin,
    input  logic        wr_n,
    input  logic [7:0]  irq,
    output logic        intrq,
    output logic [7:0]  dout,
    output logic        dout_en,
    output logic        inta
);

    logic [7:0] irq_s1_r, irq_s2_r, irq_s3_r;
    logic [7:0] mask_r, pend_r, isr_r;
    logic [2:0] vec_r;
    logic       vec_spur_r;
    logic       dbin_q_r;
    logic       wr_n_q_r;

    logic [7:0] edge_s;
    logic [7:0] elig_s;
    logic [2:0] win_s;
    logic       any_s;
    logic       page_hit_s;
    logic       wr_fire_s;
    logic       ack_s;
    logic [7:0] vec_oh_s;
    logic [7:0] isr_low_s;
    logic [7:0] pend_clr_s;
    logic [7:0] pend_nxt_s;
    logic [7:0] isr_nxt_s;
    logic [7:0] mask_nxt_s;
    logic       inta_nxt_s;
    logic [7:0] dout_s;
    logic       dout_en_s;

    assign edge_s     = irq_s2_r & ~irq_s3_r;
    assign page_hit_s = (a[15:8] == BASE);
    assign wr_fire_s  = wr_n_q_r & ~wr_n & page_hit_s;
    assign ack_s      = inta & dbin_q_r & ~dbin & ~vec_spur_r;
    assign vec_oh_s   = 8'd1 << vec_r;
    // Two's-complement trick isolates the lowest set in-service bit for EOI.
    assign isr_low_s  = isr_r & (~isr_r + 8'd1);

    // Eligibility: a request is blocked by any in-service level at or above its priority.
    always_comb begin
        logic blk_v;
        blk_v  = 1'b0;
        elig_s = 8'h00;
        for (int i = 0; i < 8; i++) begin
            blk_v     = blk_v | isr_r[i];
            elig_s[i] = pend_r[i] & ~mask_r[i] & ~blk_v;
        end
    end

    // Priority encode: lowest eligible index wins.
    always_comb begin
        win_s = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            win_s = elig_s[i] ? i[2:0] : win_s;
        end
        any_s = |elig_s;
    end

    // Next-state for pend/isr/mask; an incoming edge beats any clear, EOI precedes ack set.
    always_comb begin
        pend_clr_s = (ack_s ? vec_oh_s : 8'h00)
                   | ((wr_fire_s && a[1:0] == 2'd1) ? din : 8'h00);
        pend_nxt_s = (pend_r & ~pend_clr_s) | edge_s;
        isr_nxt_s  = (isr_r & ~((wr_fire_s && a[1:0] == 2'd2) ? isr_low_s : 8'h00))
                   | (ack_s ? vec_oh_s : 8'h00);
        mask_nxt_s = (wr_fire_s && a[1:0] == 2'd0) ? din : mask_r;
        inta_nxt_s = sync ? din[0] : inta;
    end

    // Read-data mux: INTA opcode or register window, idle otherwise.
    always_comb begin
        dout_s    = 8'h00;
        dout_en_s = 1'b0;
        if (inta && dbin) begin
            dout_s    = 8'hC7 | {2'b00, vec_r, 3'b000};
            dout_en_s = 1'b1;
        end else if (!inta && dbin && page_hit_s) begin
            dout_en_s = 1'b1;
            case (a[1:0])
                2'd0:    dout_s = mask_r;
                2'd1:    dout_s = pend_r;
                2'd2:    dout_s = isr_r;
                2'd3:    dout_s = {5'b00000, win_s};
                default: dout_s = 8'h00;
            endcase
        end else begin
            dout_s    = 8'h00;
            dout_en_s = 1'b0;
        end
    end

    assign dout    = dout_s;
    assign dout_en = dout_en_s;

    // Controller state: synchronisers, registers, INTA tracking and the CPU interrupt line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_s1_r   <= 8'h00;
            irq_s2_r   <= 8'h00;
            irq_s3_r   <= 8'h00;
            mask_r     <= 8'hFF;
            pend_r     <= 8'h00;
            isr_r      <= 8'h00;
            vec_r      <= 3'd0;
            vec_spur_r <= 1'b0;
            dbin_q_r   <= 1'b0;
            wr_n_q_r   <= 1'b1;
            inta       <= 1'b0;
            intrq      <= 1'b0;
        end else begin
            irq_s1_r <= irq;
            irq_s2_r <= irq_s1_r;
            irq_s3_r <= irq_s2_r;
            mask_r   <= mask_nxt_s;
            pend_r   <= pend_nxt_s;
            isr_r    <= isr_nxt_s;
            dbin_q_r <= dbin;
            wr_n_q_r <= wr_n;
            inta     <= inta_nxt_s;
            intrq    <= any_s & ~inta_nxt_s;
            // Vector is frozen at status time so later mask writes cannot disturb it.
            if (sync) begin
                vec_r      <= any_s ? win_s : SPUR_VEC;
                vec_spur_r <= ~any_s;
            end else begin
                vec_r      <= vec_r;
                vec_spur_r <= vec_spur_r;
            end
        end
    end

endmodule
